// File: rtl/switch_sel_debounce.sv
// switch_sel_debounce: synchronizes and debounces two push-buttons into a
// registered 2-bit demux select with change and per-switch press strobes.
module switch_sel_debounce #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   output logic o_Sel0,
   output logic o_Sel1,
   output logic o_Sel_Change,
   output logic o_Press_1,
   output logic o_Press_2
);
   localparam int CW = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

   typedef enum logic {STABLE, CHECKING} state_t;

   logic [1:0] raw, db, sel, press;
   logic       change;

   assign raw = {i_Switch_2, i_Switch_1};

   for (genvar s = 0; s < 2; s++) begin : g_sw
      logic          meta, synced, deb, deb_next;
      logic [CW-1:0] cnt, cnt_next;
      state_t        state, state_next;

      always_ff @(posedge i_Clk or negedge i_Rst_L)
         if (!i_Rst_L) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            deb    <= 1'b0;
            cnt    <= '0;
            state  <= STABLE;
         end else begin
            meta   <= raw[s];
            synced <= meta;
            deb    <= deb_next;
            cnt    <= cnt_next;
            state  <= state_next;
         end

      // A mismatch that survives to the last count is accepted; any return to
      // the debounced level drops back to STABLE with a cleared counter.
      always_comb begin
         state_next = STABLE;
         cnt_next   = '0;
         deb_next   = deb;
         if (synced != deb) begin
            if (state == CHECKING && cnt == LAST)
               deb_next = synced;
            else begin
               state_next = CHECKING;
               cnt_next   = cnt + CW'(1);
            end
         end
      end

      assign db[s] = deb;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L)
      if (!i_Rst_L) begin
         sel    <= 2'b00;
         change <= 1'b0;
         press  <= 2'b00;
      end else begin
         sel    <= db;
         change <= db != sel;
         press  <= db & ~sel;
      end

   assign o_Sel0       = sel[0];
   assign o_Sel1       = sel[1];
   assign o_Sel_Change = change;
   assign o_Press_1    = press[0];
   assign o_Press_2    = press[1];
endmodule

// File: doc/switch_sel_debounce.md
# switch_sel_debounce

Debounces the two board push-buttons and presents them as a clean, atomically updated 2-bit select for the 1-to-4 LED demux. Each switch gets a 2-flop synchronizer and an integrating debounce counter. Select outputs update only from debounced state, with a one-cycle change strobe and per-switch press strobes for downstream control. The block sits between the raw `i_Switch_1`/`i_Switch_2` pins and the demux select inputs.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required to accept a new switch level (10 ms at 25 MHz). Legal range is ≥ 2.
- `i_Clk` input, 1 bit: the single system clock. All logic is on the rising edge.
- `i_Rst_L` input, 1 bit: asynchronous, active-low reset. Its deassertion is synchronous to `i_Clk`, guaranteed externally.
- `i_Switch_1` input, 1 bit: raw, asynchronous, bouncing switch; 1 = pressed.
- `i_Switch_2` input, 1 bit: raw, asynchronous, bouncing switch; 1 = pressed.
- `o_Sel0` output, 1 bit: debounced Switch_1 level, registered. Drives demux `i_Sel0`.
- `o_Sel1` output, 1 bit: debounced Switch_2 level, registered. Drives demux `i_Sel1`.
- `o_Sel_Change` output, 1 bit: one-cycle pulse in the cycle `{o_Sel1,o_Sel0}` takes a new value.
- `o_Press_1` output, 1 bit: one-cycle pulse on debounced 0→1 of Switch_1.
- `o_Press_2` output, 1 bit: one-cycle pulse on debounced 0→1 of Switch_2.

## Operation
- **Reset (`i_Rst_L`=0):** all state clears immediately: synchronizer flops, counters, debounced levels and all outputs go to 0.
- **Synchronizer:** two flops per switch. Only the second-stage value ("synced") is used downstream.
- **Per-switch debounce FSM:**
  - STABLE: synced == debounced, counter = 0.
  - CHECKING: synced != debounced. The counter increments each cycle.
  - STABLE→CHECKING: on the first cycle of mismatch.
  - CHECKING→STABLE, rejected: synced returns to the debounced value before acceptance. Counter clears; debounced is unchanged.
  - CHECKING→STABLE, accepted: mismatch persists while counter == `DEBOUNCE_LIMIT`-1. On that edge debounced <= synced and counter <= 0.
- **Counter:** width is $clog2(`DEBOUNCE_LIMIT`), unsigned. It never exceeds `DEBOUNCE_LIMIT`-1 and never wraps.
- **Select register:** on every edge, `{o_Sel1,o_Sel0}` <= `{db2,db1}`.
  - `o_Sel_Change` <= (`{db2,db1}` != `{o_Sel1,o_Sel0}`).
  - `o_Press_n` <= db_n & ~o_Sel_n.
- **Simultaneous acceptance:** if both switches are accepted on the same edge, both bits update together, with a single `o_Sel_Change` pulse and both press pulses in the same cycle.
- **Acceptance on consecutive edges:** produces two separate `o_Sel_Change` pulses. An intermediate select value is visible for one cycle.
- **Release:** a debounced 1→0 produces an `o_Sel_Change` pulse but no `o_Press_n`.
- **Reset mid-count:** any count in progress is discarded. A switch held pressed through reset re-debounces from zero and needs the full latency after deassertion.

## Timing
- **Press latency:** a raw level first sampled at edge k, then held, gives:
  - synced = new level after edge k+1;
  - debounced flips at edge k+1+`DEBOUNCE_LIMIT`;
  - `o_Sel_n`, `o_Sel_Change` and `o_Press_n` assert at edge k+2+`DEBOUNCE_LIMIT`;
  - total latency is `DEBOUNCE_LIMIT`+2 edges.
- **Glitch rejection:** any synced excursion lasting fewer than `DEBOUNCE_LIMIT` consecutive cycles produces no output change.
- **Pulse width:** every strobe is exactly one `i_Clk` cycle wide. A steady switch never retriggers a strobe.
- **Outputs:** all outputs are registered. There is no combinational path from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_LIMIT`=4.
- **Reset values:** hold `i_Rst_L`=0 with both switches at 1 → all outputs 0. Deassert, keep switches at 1 → `o_Sel0`=`o_Sel1`=1 and a single `o_Sel_Change`, `o_Press_1`, `o_Press_2` pulse 6 edges after the first sampling edge.
- **Clean press:** `i_Switch_1` 0→1, first sampled at edge k, held → `o_Sel0`=1, `o_Sel_Change`=1 and `o_Press_1`=1 at edge k+6 only. Strobes return to 0 at k+7.
- **Bounce rejection:** `i_Switch_2` toggles 1,0,1,0 on alternate cycles, then holds at 1 → `o_Sel1` rises exactly 6 edges after the final 0→1 sample, with one `o_Press_2` pulse. A 3-cycle high glitch → no output change.
- **Simultaneous press:** both switches rise on the same edge k → `{o_Sel1,o_Sel0}` goes 00→11 at k+6, with one `o_Sel_Change` pulse and both press pulses in that cycle.
- **Staggered press:** Switch_1 sampled at edge k, Switch_2 at edge k+1 → select goes 00→01 at k+6 and 01→11 at k+7. `o_Sel_Change` is high for both cycles.
- **Reset mid-operation:** assert `i_Rst_L` when the counter = 2, then release with the switch still high → outputs go to 0 immediately. `o_Sel0` rises 6 edges after the first post-reset sampling edge.
